disp_source_scheduler: RTL
==========================

// Module: disp_source_scheduler
// PURPOSE
//  Selects which 24-bit source feeds the FND display path: stopwatch, watch, SR04 distance or DHT11.
//  The source is stepped by the mode button or by an auto-rotate dwell timer.
//  Paces start requests to the SR04 and DHT11 controllers while their page is shown.
//  Latches sensor results, flags stale readings, and registers the selected word for the display.
// PARAMETERS
//  DATA_W     24  width of every source word and of out_data
//  AUTO_SEC    3  auto-rotate dwell per page, in tick_1hz pulses (1..15)
//  SR04_PER    1  ticks between SR04 start requests while on the SR04 page
//  DHT_PER     2  ticks between DHT11 start requests (DHT11 needs >=2 s spacing)
//  STALE_SEC   4  ticks after a request with no valid before the stale flag sets
// PORTS
//  clk          in   1       system clock, 100 MHz
//  rst_n        in   1       asynchronous, active-low reset
//  tick_1hz     in   1       1-cycle pulse, once per second
//  btn_mode     in   1       debounced 1-cycle pulse; advance page
//  auto_en      in   1       level; 1 = auto-rotate enabled
//  swatch_data  in   DATA_W  stopwatch time word
//  watch_data   in   DATA_W  watch time word
//  sr04_data    in   DATA_W  distance result; qualified by sr04_valid
//  sr04_valid   in   1       1-cycle pulse, new distance result
//  sr04_busy    in   1       SR04 controller measuring
//  dht_data     in   DATA_W  temperature/humidity result; qualified by dht_valid
//  dht_valid    in   1       1-cycle pulse, new DHT11 result
//  dht_busy     in   1       DHT11 controller transferring
//  sr04_start   out  1       1-cycle start request to the SR04 controller
//  dht_start    out  1       1-cycle start request to the DHT11 controller
//  out_data     out  DATA_W  registered display word
//  out_src      out  2       page of out_data: 0 SWATCH, 1 WATCH, 2 SR04, 3 DHT
//  out_stale    out  1       1 when out_src is a sensor page and that sensor is stale
// BEHAVIOUR
//  Reset (async, rst_n=0): page=SWATCH. All outputs, latches, counters and stale flags = 0.
//   Any pending start request is dropped. Reset takes effect immediately, mid-operation included.
//  Page FSM: SWATCH->WATCH->SR04->DHT->SWATCH.
//   Advance on btn_mode, or on dwell expiry when auto_en=1.
//   Both events in one cycle: advance by exactly one page.
//  Dwell counter: counts tick_1hz on the current page.
//   Expiry is the tick that brings the count to AUTO_SEC.
//   Clears on every page change and while auto_en=0.
//  Sensor request (identical per sensor, own period P and busy input):
//   Pending flag sets on the cycle after entering that sensor's page.
//   Pending flag sets again every P ticks while on the page.
//   When pending=1 and busy=0: start pulses 1 cycle and pending clears. While busy=1, pending holds.
//   Leaving the page clears pending. A start never fires when the page is not the sensor's page.
//   At most one start per sensor per clock cycle.
//  Sensor latch: on *_valid, capture *_data regardless of current page.
//   The latch holds until the next valid; reset value is 0.
//  Stale: per-sensor tick counter starts at each start pulse and clears on *_valid.
//   Stale flag sets when the counter reaches STALE_SEC; counter saturates there.
//   Stale flag clears on the next *_valid.
//  Output register, 1-cycle latency:
//   SWATCH/WATCH pages pass the live input through.
//   SR04/DHT pages output the latched sensor word.
//   out_src and out_stale update in the same cycle as out_data.
//   Valid and page change in the same cycle: out_data shows the new page with the new latch value on the next cycle.
//  Width rules: all counters are 4-bit saturating; no arithmetic on data words.
// STRUCTURE
//  Shared package disp_pkg: page encodings SRC_SWATCH..SRC_DHT (2-bit), DATA_W default, counter width.
//  One sub-module, sensor_req_timer, instantiated twice (SR04, DHT11).
//   Inputs: page_active, tick, busy, valid. Parameters: P, STALE_SEC.
//   Outputs: start, stale.
//  The top level holds the page FSM, dwell counter, sensor latches and output register.
// TESTING
//  1 Reset, then 4 btn_mode pulses -> out_src 0,1,2,3,0; each change 1 cycle after its pulse.
//  2 auto_en=1, 7 ticks -> page changes on tick 3 and tick 6. btn_mode on the tick-3 cycle -> single advance only.
//  3 SR04 page with sr04_busy=0 -> sr04_start on entry+1 cycle and on every tick.
//    Hold sr04_busy=1 for 3 cycles -> start delayed until busy falls. No start after leaving the page.
//  4 DHT page, dht_valid with 24'h1A2B3C while page=WATCH -> on entering DHT, out_data=24'h1A2B3C.
//  5 DHT page, no dht_valid for 4 ticks after start -> out_stale=1. Next dht_valid -> out_stale=0 next cycle.
//  6 rst_n low mid-request (pending=1, page=SR04) -> all outputs 0, page SWATCH, no start after release.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared definitions for the display source scheduler: page encodings and widths.
package disp_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    SRC_SWATCH = 2'd0,
    SRC_WATCH  = 2'd1,
    SRC_SR04   = 2'd2,
    SRC_DHT    = 2'd3
  } src_e;

  // Page rotation order: SWATCH -> WATCH -> SR04 -> DHT -> SWATCH.
  function automatic src_e next_src(input src_e s);
    case (s)
      SRC_SWATCH: next_src = SRC_WATCH;
      SRC_WATCH:  next_src = SRC_SR04;
      SRC_SR04:   next_src = SRC_DHT;
      default:    next_src = SRC_SWATCH;
    endcase
  endfunction

endpackage

// File: rtl/sensor_req_timer.sv
// Paces start requests to one sensor controller while its page is shown,
// and flags the sensor stale when no result follows a request in time.
module sensor_req_timer
  import disp_pkg::*;
#(
  parameter int P         = 1,
  parameter int STALE_SEC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic page_active,
  input  logic tick,
  input  logic busy,
  input  logic valid,
  output logic start,
  output logic stale
);

  localparam logic [CNT_W-1:0] PER_LIM   = CNT_W'(P);
  localparam logic [CNT_W-1:0] STALE_LIM = CNT_W'(STALE_SEC);

  logic             active_q;
  logic             pending;
  logic             running;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] stale_cnt;
  logic             entry;
  logic             per_hit;

  // Start is gated by the live page so a request can never leak onto another page.
  assign start = pending & ~busy & page_active;

  // Page entry and period expiry are the two events that arm a request.
  always_comb begin
    entry   = page_active & ~active_q;
    per_hit = page_active & tick & ((per_cnt + CNT_W'(1)) == PER_LIM);
  end

  // Request pacing: period counter and pending flag, both dropped when off the page.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      per_cnt  <= '0;
      pending  <= 1'b0;
    end else begin
      active_q <= page_active;
      if (!page_active) begin
        per_cnt <= '0;
        pending <= 1'b0;
      end else begin
        if (per_hit)
          per_cnt <= '0;
        else if (tick && per_cnt != '1)
          per_cnt <= per_cnt + CNT_W'(1);
        // A fresh arming event wins over consumption so no request is lost.
        if (entry || per_hit)
          pending <= 1'b1;
        else if (start)
          pending <= 1'b0;
      end
    end
  end

  // Staleness: timed from the oldest unanswered start, so periodic re-requests do not hide a dead sensor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running   <= 1'b0;
      stale_cnt <= '0;
      stale     <= 1'b0;
    end else if (valid) begin
      running   <= start;
      stale_cnt <= '0;
      stale     <= 1'b0;
    end else if (start && !running) begin
      running   <= 1'b1;
      stale_cnt <= '0;
    end else if (running && tick && stale_cnt != STALE_LIM) begin
      stale_cnt <= stale_cnt + CNT_W'(1);
      if ((stale_cnt + CNT_W'(1)) == STALE_LIM)
        stale <= 1'b1;
    end
  end

endmodule

// File: rtl/disp_source_scheduler.sv
// Chooses the word shown on the FND display, rotates pages, and latches sensor results.
//  state      | meaning
//  SRC_SWATCH | stopwatch word passed through
//  SRC_WATCH  | watch word passed through
//  SRC_SR04   | latched distance shown, SR04 requests paced
//  SRC_DHT    | latched temp/humidity shown, DHT11 requests paced
module disp_source_scheduler
  import disp_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int AUTO_SEC  = 3,
  parameter int SR04_PER  = 1,
  parameter int DHT_PER   = 2,
  parameter int STALE_SEC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_1hz,
  input  logic              btn_mode,
  input  logic              auto_en,
  input  logic [DATA_W-1:0] swatch_data,
  input  logic [DATA_W-1:0] watch_data,
  input  logic [DATA_W-1:0] sr04_data,
  input  logic              sr04_valid,
  input  logic              sr04_busy,
  input  logic [DATA_W-1:0] dht_data,
  input  logic              dht_valid,
  input  logic              dht_busy,
  output logic              sr04_start,
  output logic              dht_start,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_src,
  output logic              out_stale
);

  localparam logic [CNT_W-1:0] AUTO_LIM = CNT_W'(AUTO_SEC);

  src_e              page;
  src_e              page_nxt;
  logic [CNT_W-1:0]  dwell_cnt;
  logic              expiry;
  logic              advance;
  logic [DATA_W-1:0] sr04_lat;
  logic [DATA_W-1:0] dht_lat;
  logic [DATA_W-1:0] sr04_cur;
  logic [DATA_W-1:0] dht_cur;
  logic              sr04_stale;
  logic              dht_stale;

  // Next page and bypassed latch values let the output register reflect this cycle's events.
  always_comb begin
    expiry   = auto_en & tick_1hz & ((dwell_cnt + CNT_W'(1)) == AUTO_LIM);
    advance  = btn_mode | expiry;
    page_nxt = advance ? next_src(page) : page;
    sr04_cur = sr04_valid ? sr04_data : sr04_lat;
    dht_cur  = dht_valid ? dht_data : dht_lat;
  end

  // Page FSM and dwell counter; button and expiry together still advance only one page.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page      <= SRC_SWATCH;
      dwell_cnt <= '0;
    end else begin
      page <= page_nxt;
      if (!auto_en || advance)
        dwell_cnt <= '0;
      else if (tick_1hz && dwell_cnt != '1)
        dwell_cnt <= dwell_cnt + CNT_W'(1);
    end
  end

  // Sensor results are captured whatever page is on screen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr04_lat <= '0;
      dht_lat  <= '0;
    end else begin
      sr04_lat <= sr04_cur;
      dht_lat  <= dht_cur;
    end
  end

  // Registered display word, page tag and stale flag, all updated together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_src   <= 2'd0;
      out_stale <= 1'b0;
    end else begin
      out_src <= page_nxt;
      case (page_nxt)
        SRC_SWATCH: begin out_data <= swatch_data; out_stale <= 1'b0; end
        SRC_WATCH:  begin out_data <= watch_data;  out_stale <= 1'b0; end
        SRC_SR04:   begin out_data <= sr04_cur;    out_stale <= sr04_stale & ~sr04_valid; end
        default:    begin out_data <= dht_cur;     out_stale <= dht_stale & ~dht_valid; end
      endcase
    end
  end

  sensor_req_timer #(.P(SR04_PER), .STALE_SEC(STALE_SEC)) u_sr04_req (
    .clk         (clk),
    .rst_n       (rst_n),
    .page_active (page == SRC_SR04),
    .tick        (tick_1hz),
    .busy        (sr04_busy),
    .valid       (sr04_valid),
    .start       (sr04_start),
    .stale       (sr04_stale)
  );

  sensor_req_timer #(.P(DHT_PER), .STALE_SEC(STALE_SEC)) u_dht_req (
    .clk         (clk),
    .rst_n       (rst_n),
    .page_active (page == SRC_DHT),
    .tick        (tick_1hz),
    .busy        (dht_busy),
    .valid       (dht_valid),
    .start       (dht_start),
    .stale       (dht_stale)
  );

endmodule
